joypad_port: RTL and testbench
==============================

Name: joypad_port

Overview:
- Single-player controller front end between a 3-button Genesis-style pad (6 data pins plus a select line) and the CPU's $4016/$4017 GPIO interface.
- Periodically scans the pad by toggling the select line and maps the result to the 8 NES buttons.
- Presents the buttons through an NES-compatible 4021-style latch/shift register read one bit per CPU read.
- Instantiated once per port, alongside the core's GPIO pins.

Parameters:
- P_scan_period, 16384, clock cycles from the start of one scan to the start of the next (>= 4*P_settle).
- P_settle, 32, clock cycles to wait after changing O_joy_mode before sampling the pins (>= 3, covers the 2-flop synchronizer).

Ports:
- I_clock  input  1  system clock.
- I_reset  input  1  synchronous, active-low reset.
- I_joy_bits  input  6  pad pins, active-low, asynchronous.
- O_joy_mode  output  1  pad select line.
- I_GPIO_load  input  1  CPU strobe level, from $4016 bit 0 write.
- I_GPIO_rden  input  1  high while the CPU reads this port.
- O_GPIO_data  output  1  current serial button bit, active-high pressed.

Behaviour:
- Reset:
  - Reset is synchronous, active-low (I_reset=0 sampled on the I_clock edge).
  - O_joy_mode=1, buttons=8'h00, shift register=8'h00, O_GPIO_data=0.
  - FSM=IDLE, counters=0, synchronizers=6'h3F.
  - Reset mid-scan aborts the scan with no commit.
- Input synchronizer:
  - I_joy_bits passes through 2 flops; "pins" below means the synchronized value.
- Pad pin meaning:
  - Select high: pins[5:0] = {C,B,Right,Left,Down,Up}.
  - Select low: pins[5:0] = {Start,A,0,0,Down,Up}.
- Scan FSM (one cycle per transition):
  - IDLE: O_joy_mode=1. Period counter counts to P_scan_period-2*P_settle-1, then → SETTLE_HI.
  - SETTLE_HI: O_joy_mode=1. After P_settle cycles, capture hi=~pins; drive O_joy_mode=0; → SETTLE_LO.
  - SETTLE_LO: O_joy_mode=0. After P_settle cycles, capture lo=pins; → COMMIT.
  - COMMIT: O_joy_mode=1; update buttons; → IDLE.
  - Scan start-to-start is exactly P_scan_period cycles.
- Button mapping (NES order, bit0 first out):
  - {Right,Left,Down,Up,Start,Select,B,A} = {hi[3],hi[2],hi[1],hi[0],~lo[5],~lo[4],hi[4],hi[5]}.
  - A=C, B=B, Select=A, Start=Start.
  - Presence check: if lo[3:2]!=2'b00 at COMMIT, no pad is present and buttons=8'h00.
  - Buttons update atomically only in COMMIT; between commits the value is held.
- Shift register:
  - While I_GPIO_load=1, reloads from buttons every cycle, including a COMMIT in the same cycle (uses the new value).
  - While I_GPIO_load=0, shifts right on the falling edge of I_GPIO_rden (registered rden=1, current rden=0). Fill bit is 1.
  - O_GPIO_data = sr[0] registered, so it is stable throughout a read.
  - After 8 shifts the register is all 1s, so the 9th and later reads return 1.
  - Load and a rden falling edge in the same cycle: load wins.
  - A read with I_GPIO_load=1 returns button A repeatedly with no shift.
  - A rden pulse held for many cycles still produces one shift.
- Latency:
  - Pin change to buttons: at most P_scan_period + P_settle + 3 cycles.
  - Strobe to O_GPIO_data: 2 cycles (load register, then output register).

Test Plan:
- Reset with I_reset=0 for 4 cycles, pins=6'h3F → O_joy_mode=1, O_GPIO_data=0; after release, O_joy_mode falls exactly P_scan_period-P_settle cycles later and stays low P_settle cycles.
- Pad model (Left, B, Start pressed) responding to O_joy_mode; wait one scan; load=1 then 0; 10 read pulses → serial bits 0,1,0,1,0,0,1,0,1,1.
- Pad model returns lo[3:2]=2'b11 (no pad): after COMMIT, strobe and 8 reads → all 0; 9th read → 1.
- Strobe held high while reading 3 times, A pressed → 1,1,1, no shift; drop strobe → next reads continue B, Select, ...
- Button pressed during a scan (change pins between SETTLE_HI and SETTLE_LO) → buttons change only at COMMIT, never a partial value; O_GPIO_data is steady while rden=1.
- Reset asserted during SETTLE_LO → O_joy_mode=1 the next cycle, buttons stay 8'h00, the next scan starts cleanly.

Source files
------------

// File: rtl/joypad_port.sv
// Purpose: scans a 3-button Genesis-style pad and presents it as an NES 4021-style serial port.
// Latency: pin change to buttons <= P_scan_period+P_settle+3 cycles; strobe to O_GPIO_data 2 cycles.
// Backpressure: none; the CPU pulls one bit per falling edge of I_GPIO_rden, and strobe overrides shifting.
module joypad_port #(
    parameter int P_scan_period = 16384,
    parameter int P_settle      = 32
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic [5:0] I_joy_bits,
    output logic       O_joy_mode,
    input  logic       I_GPIO_load,
    input  logic       I_GPIO_rden,
    output logic       O_GPIO_data
);

    localparam int CW = $clog2(P_scan_period);

    // IDLE after reset lasts P_scan_period-2*P_settle cycles; in steady state COMMIT
    // takes the first of those cycles, so scan start-to-start is exactly P_scan_period.
    localparam logic [CW-1:0] IDLE_LAST   = CW'(P_scan_period - 2*P_settle - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(P_settle - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HI     = 2'd1;
    localparam logic [1:0] S_LO     = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [5:0]    sync1_q, sync1_d;
    logic [5:0]    sync2_q, sync2_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    hi_q, hi_d;      // select-high pins, inverted to active-high
    logic [3:0]    lo_q, lo_d;      // select-low pins[5:2], raw (pins[1:0] are unused there)
    logic          mode_q, mode_d;
    logic [7:0]    buttons_q, buttons_d;
    logic [7:0]    sr_q, sr_d;
    logic          rden_q, rden_d;
    logic          data_q, data_d;
    logic          rden_fall;

    assign O_joy_mode  = mode_q;
    assign O_GPIO_data = data_q;

    // Scan sequencer: settle with select high, settle with select low, then commit atomically.
    always_comb begin
        sync1_d   = I_joy_bits;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        buttons_d = buttons_q;
        case (state_q)
            S_IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HI: begin
                if (cnt_q == SETTLE_LAST) begin
                    hi_d    = ~sync2_q;
                    state_d = S_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LO: begin
                if (cnt_q == SETTLE_LAST) begin
                    lo_d    = sync2_q[5:2];
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // A real pad drives pins[3:2] low while select is low; anything else means no pad.
                if (lo_q[1:0] != 2'b00) begin
                    buttons_d = 8'h00;
                end else begin
                    buttons_d = {hi_q[3], hi_q[2], hi_q[1], hi_q[0],
                                 ~lo_q[3], ~lo_q[2], hi_q[4], hi_q[5]};
                end
                state_d = S_IDLE;
                cnt_d   = CW'(1);
            end
        endcase
        mode_d = (state_d != S_LO);
    end

    // CPU side: strobe reloads (seeing a same-cycle commit), falling rden shifts in 1s.
    always_comb begin
        rden_fall = rden_q & ~I_GPIO_rden;
        rden_d    = I_GPIO_rden;
        sr_d      = sr_q;
        if (I_GPIO_load) begin
            sr_d = buttons_d;
        end else if (rden_fall) begin
            sr_d = {1'b1, sr_q[7:1]};
        end
        data_d = sr_q[0];
    end

    // State registers with synchronous active-low reset; reset mid-scan discards the scan.
    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            sync1_q   <= 6'h3F;
            sync2_q   <= 6'h3F;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 6'h00;
            lo_q      <= 4'h0;
            mode_q    <= 1'b1;
            buttons_q <= 8'h00;
            sr_q      <= 8'h00;
            rden_q    <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mode_q    <= mode_d;
            buttons_q <= buttons_d;
            sr_q      <= sr_d;
            rden_q    <= rden_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port with a combinational pad model driven by the select line.
// Short scan period keeps the run small; all expected values are hand-derived constants.
// Outputs are sampled on the falling clock edge, inputs driven there too.
module tb_joypad_port;

    localparam int PS = 256;
    localparam int PT = 8;

    logic       clk;
    logic       I_reset;
    logic [5:0] I_joy_bits;
    logic       O_joy_mode;
    logic       I_GPIO_load;
    logic       I_GPIO_rden;
    logic       O_GPIO_data;

    // pad buttons, active-high pressed
    logic pc, pb, pr, pl, pd, pu, pst, pa;
    logic no_pad;

    int total = 0;
    int bad   = 0;

    joypad_port #(.P_scan_period(PS), .P_settle(PT)) dut (
        .I_clock     (clk),
        .I_reset     (I_reset),
        .I_joy_bits  (I_joy_bits),
        .O_joy_mode  (O_joy_mode),
        .I_GPIO_load (I_GPIO_load),
        .I_GPIO_rden (I_GPIO_rden),
        .O_GPIO_data (O_GPIO_data)
    );

    // Pad: select high -> {C,B,R,L,D,U}; select low -> {Start,A,0,0,D,U}; all active-low.
    // Without a pad the select-low pins[3:2] float high.
    assign I_joy_bits = O_joy_mode ? ~{pc, pb, pr, pl, pd, pu}
                                   : {~pst, ~pa, (no_pad ? 2'b11 : 2'b00), ~pd, ~pu};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // v = {C,B,Right,Left,Down,Up,Start,A}
    task automatic press(input logic [7:0] v);
        {pc, pb, pr, pl, pd, pu, pst, pa} = v;
    endtask

    task automatic wait_mode(input logic v, input string tag);
        int n = 0;
        while (O_joy_mode !== v && n < 2*PS) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, O_joy_mode}, {7'd0, v});
    endtask

    task automatic wait_commit();
        wait_mode(1'b0, "wait_lo");
        wait_mode(1'b1, "wait_commit");
        tick();
        tick();
    endtask

    task automatic strobe();
        I_GPIO_load = 1'b1;
        tick();
        tick();
        I_GPIO_load = 1'b0;
    endtask

    // One CPU read: data must hold steady for the whole pulse, then shift after it.
    task automatic read_bit(input logic exp, input string tag);
        I_GPIO_rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(tag, {7'd0, O_GPIO_data}, {7'd0, exp});
        end
        I_GPIO_rden = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        I_reset     = 1'b0;
        I_GPIO_load = 1'b0;
        I_GPIO_rden = 1'b0;
        no_pad      = 1'b0;
        press(8'h00);

        // Reset state and first-scan select timing
        repeat (4) tick();
        chk("rst_mode", {7'd0, O_joy_mode}, 8'd1);
        chk("rst_data", {7'd0, O_GPIO_data}, 8'd0);
        I_reset = 1'b1;
        press(8'b0101_0010);             // Left, B, Start
        repeat (PS-PT-1) tick();
        chk("mode_pre_fall", {7'd0, O_joy_mode}, 8'd1);
        tick();
        chk("mode_fall", {7'd0, O_joy_mode}, 8'd0);
        repeat (PT-1) tick();
        chk("mode_low_end", {7'd0, O_joy_mode}, 8'd0);
        tick();
        chk("mode_rise", {7'd0, O_joy_mode}, 8'd1);

        // Left, B, Start -> 0,1,0,1,0,0,1,0 then fill 1s
        tick();
        strobe();
        read_bit(1'b0, "t1_A");
        read_bit(1'b1, "t1_B");
        read_bit(1'b0, "t1_Sel");
        read_bit(1'b1, "t1_St");
        read_bit(1'b0, "t1_U");
        read_bit(1'b0, "t1_D");
        read_bit(1'b1, "t1_L");
        read_bit(1'b0, "t1_R");
        read_bit(1'b1, "t1_fill9");
        read_bit(1'b1, "t1_fill10");

        // Strobe held: A repeats without shifting; last read's fall after strobe drop shifts
        press(8'b1000_0001);             // C (NES A), pad A (NES Select)
        wait_commit();
        I_GPIO_load = 1'b1;
        tick();
        tick();
        read_bit(1'b1, "hold_rd0");
        read_bit(1'b1, "hold_rd1");
        I_GPIO_rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rd2", {7'd0, O_GPIO_data}, 8'd1);
        end
        I_GPIO_load = 1'b0;
        tick();
        I_GPIO_rden = 1'b0;
        tick();
        tick();
        read_bit(1'b0, "hold_B");
        read_bit(1'b1, "hold_Sel");
        read_bit(1'b0, "hold_St");

        // Press C and Start after the select-high capture: only Start lands this commit
        press(8'h00);
        wait_commit();
        I_GPIO_load = 1'b1;
        tick();
        tick();
        chk("mid_pre", {7'd0, O_GPIO_data}, 8'd0);
        wait_mode(1'b0, "mid_lo");
        press(8'b1000_0010);
        for (int i = 0; i < PT; i++) begin
            chk("mid_hold", {7'd0, O_GPIO_data}, 8'd0);
            tick();
        end
        chk("mid_commit", {7'd0, O_joy_mode}, 8'd1);
        tick();
        chk("mid_after1", {7'd0, O_GPIO_data}, 8'd0);
        tick();
        chk("mid_after2", {7'd0, O_GPIO_data}, 8'd0);
        I_GPIO_load = 1'b0;
        read_bit(1'b0, "mid_A");
        read_bit(1'b0, "mid_B");
        read_bit(1'b0, "mid_Sel");
        read_bit(1'b1, "mid_St");
        I_GPIO_load = 1'b1;
        wait_commit();
        chk("mid_next_A", {7'd0, O_GPIO_data}, 8'd1);
        I_GPIO_load = 1'b0;

        // No pad: presence check forces zero despite C and Start still held
        no_pad = 1'b1;
        wait_commit();
        strobe();
        for (int i = 0; i < 8; i++) read_bit(1'b0, "nopad_bit");
        read_bit(1'b1, "nopad_fill9");
        read_bit(1'b1, "nopad_fill10");

        // Reset in the select-low phase: no commit, clean restart
        no_pad = 1'b0;
        press(8'b1000_0000);             // C
        wait_mode(1'b0, "rst_mid_lo");
        tick();
        tick();
        I_reset = 1'b0;
        tick();
        chk("rst_mid_mode", {7'd0, O_joy_mode}, 8'd1);
        chk("rst_mid_data", {7'd0, O_GPIO_data}, 8'd0);
        I_reset     = 1'b1;
        I_GPIO_load = 1'b1;
        repeat (PS-PT-1) tick();
        chk("rst_no_commit", {7'd0, O_GPIO_data}, 8'd0);
        chk("rst2_pre_fall", {7'd0, O_joy_mode}, 8'd1);
        tick();
        chk("rst2_fall", {7'd0, O_joy_mode}, 8'd0);
        repeat (PT) tick();
        chk("rst2_rise", {7'd0, O_joy_mode}, 8'd1);
        chk("rst2_data0", {7'd0, O_GPIO_data}, 8'd0);
        tick();
        chk("rst2_data1", {7'd0, O_GPIO_data}, 8'd0);
        tick();
        chk("rst2_data2", {7'd0, O_GPIO_data}, 8'd1);
        I_GPIO_load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
